// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage: op/size codes, FSM states,
// byte-enable patterns and EX/MEM, MEM/WB latch payloads.
package mem_pkg;

    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b11;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [4:0]  wb;
        logic [1:0]  op;
        logic [1:0]  size;
        logic        sgn;
        logic        jl;
        logic [31:0] link;
        logic [31:0] alu;
        logic [31:0] regb;
        logic [4:0]  rd;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]  wb;
        logic        jl;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] link;
    } mem_wb_t;

    function automatic logic is_access(input logic [1:0] op);
        return (op == MEM_LOAD) || (op == MEM_STORE);
    endfunction

    // Stores never write the register file; only loads carry memory data forward.
    function automatic mem_wb_t to_mem_wb(input ex_mem_t e, input logic [31:0] load_data);
        mem_wb_t w;
        w.wb    = (e.op == MEM_STORE) ? 5'd0 : e.wb;
        w.jl    = e.jl;
        w.rdata = (e.op == MEM_LOAD) ? load_data : 32'd0;
        w.alu   = e.alu;
        w.rd    = e.rd;
        w.link  = e.link;
        return w;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data-memory accesses: byte enables, store-data replication,
// load extraction/extension and alignment check. Subword support under SUBWORD_ACCESS_EN.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

`ifdef SUBWORD_ACCESS_EN
    logic [31:0] shifted;

    always_comb begin
        be         = BE_WORD;
        wdata      = store_data;
        misaligned = 1'b0;
        shifted    = rdata >> {addr_lo, 3'b000};
        load_data  = rdata;
        if (size == SZ_BYTE) begin
            be        = BE_BYTE0 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
        end else if (size == SZ_HALF) begin
            be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata      = {2{store_data[15:0]}};
            load_data  = {{16{sgn & shifted[15]}}, shifted[15:0]};
            misaligned = addr_lo[0];
        end else begin
            misaligned = (addr_lo != 2'b00);
        end
    end
`else
    // Word-only build: size/sign controls and subword constants have no effect.
    logic unused_cfg;
    assign unused_cfg = ^{size, sgn, SZ_BYTE, SZ_HALF, BE_HALF_LO, BE_HALF_HI, BE_BYTE0};

    assign be         = BE_WORD;
    assign wdata      = store_data;
    assign load_data  = rdata;
    assign misaligned = (addr_lo != 2'b00);
`endif

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: runs EX/MEM loads/stores over a req/ack data-memory port, stalls upstream
// while busy and registers the MEM/WB latch on the falling edge. Option: SUBWORD_ACCESS_EN.
module memory_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    inWB,
    input  logic [1:0]    inMEM,
    input  logic [1:0]    inSize,
    input  logic          inSigned,
    input  logic          inJL,
    input  logic [31:0]   inNextInstructionAddress,
    input  logic [31:0]   inALUResult,
    input  logic [31:0]   inRegB,
    input  logic [4:0]    inRegF_wreg,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic [3:0]    dmem_be,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata,
    output logic          stall,
    output logic          mem_err,
    output logic [31:0]   MEM_AluResult,
    output logic [4:0]    MEM_rd,
    output logic          MEM_regF_wr,
    output logic [4:0]    outWB,
    output logic          outJL,
    output logic [31:0]   outReadData,
    output logic [31:0]   outALUResult,
    output logic [4:0]    outRegF_wreg,
    output logic [31:0]   outNextInstructionAddress
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    mem_state_t    state;
    logic [CW-1:0] cnt;
    ex_mem_t       live;
    ex_mem_t       held;
    ex_mem_t       act;
    mem_wb_t       wb_q;

    logic [3:0]    align_be;
    logic [31:0]   align_wdata;
    logic [31:0]   align_ldata;
    logic          align_mis;
    logic          start;
    logic          misaligned_op;
    logic          timed_out;

    always_comb begin
        live      = '0;
        live.wb   = inWB;
        live.op   = inMEM;
        live.size = inSize;
        live.sgn  = inSigned;
        live.jl   = inJL;
        live.link = inNextInstructionAddress;
        live.alu  = inALUResult;
        live.regb = inRegB;
        live.rd   = inRegF_wreg;
    end

    // While waiting, the request is driven from the captured copy so it stays stable.
    assign act = (state == ST_WAIT) ? held : live;

    mem_lane_align u_lane_align (
        .size       (act.size),
        .sgn        (act.sgn),
        .addr_lo    (act.alu[1:0]),
        .store_data (act.regb),
        .rdata      (dmem_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_ldata),
        .misaligned (align_mis)
    );

    assign start         = (state == ST_IDLE) && is_access(live.op) && !align_mis;
    assign misaligned_op = (state == ST_IDLE) && is_access(live.op) && align_mis;
    assign timed_out     = (state == ST_WAIT) && !dmem_ack && (cnt == CW'(TIMEOUT));

    // Request and stall are gated by reset so an aborted access drops at once.
    always_comb begin
        dmem_req   = rst && (start || (state == ST_WAIT));
        stall      = rst && (start || ((state == ST_WAIT) && !dmem_ack && !timed_out));
        dmem_we    = dmem_req && (act.op == MEM_STORE);
        dmem_addr  = dmem_req ? AW'(act.alu) : '0;
        dmem_wdata = dmem_req ? align_wdata : 32'd0;
        dmem_be    = dmem_req ? align_be : 4'd0;
    end

    assign MEM_regF_wr   = inWB[0] & ~(inMEM == MEM_STORE);
    assign MEM_AluResult = inJL ? inNextInstructionAddress : inALUResult;
    assign MEM_rd        = inRegF_wreg;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            held    <= '0;
            wb_q    <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_WAIT;
                        cnt   <= CW'(1);
                        held  <= live;
                    end else if (misaligned_op) begin
                        mem_err <= 1'b1;
                        wb_q    <= '0;
                    end else begin
                        wb_q <= to_mem_wb(live, 32'd0);
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        state <= ST_IDLE;
                        wb_q  <= to_mem_wb(held, align_ldata);
                    end else if (timed_out) begin
                        state   <= ST_IDLE;
                        mem_err <= 1'b1;
                        wb_q    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign outWB                     = wb_q.wb;
    assign outJL                     = wb_q.jl;
    assign outReadData               = wb_q.rdata;
    assign outALUResult              = wb_q.alu;
    assign outRegF_wreg              = wb_q.rd;
    assign outNextInstructionAddress = wb_q.link;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: flops move on negedge, so inputs are driven
// just after negedge and all outputs are sampled at the following posedge.
module tb_memory_access_stage;

    logic        clk;
    logic        rst;
    logic [4:0]  inWB;
    logic [1:0]  inMEM;
    logic [1:0]  inSize;
    logic        inSigned;
    logic        inJL;
    logic [31:0] inNextInstructionAddress;
    logic [31:0] inALUResult;
    logic [31:0] inRegB;
    logic [4:0]  inRegF_wreg;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        mem_err;
    logic [31:0] MEM_AluResult;
    logic [4:0]  MEM_rd;
    logic        MEM_regF_wr;
    logic [4:0]  outWB;
    logic        outJL;
    logic [31:0] outReadData;
    logic [31:0] outALUResult;
    logic [4:0]  outRegF_wreg;
    logic [31:0] outNextInstructionAddress;

    int tests_run;
    int tests_failed;

    memory_access_stage #(.AW(32), .TIMEOUT(16)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .inWB                     (inWB),
        .inMEM                    (inMEM),
        .inSize                   (inSize),
        .inSigned                 (inSigned),
        .inJL                     (inJL),
        .inNextInstructionAddress (inNextInstructionAddress),
        .inALUResult              (inALUResult),
        .inRegB                   (inRegB),
        .inRegF_wreg              (inRegF_wreg),
        .dmem_req                 (dmem_req),
        .dmem_we                  (dmem_we),
        .dmem_addr                (dmem_addr),
        .dmem_wdata               (dmem_wdata),
        .dmem_be                  (dmem_be),
        .dmem_ack                 (dmem_ack),
        .dmem_rdata               (dmem_rdata),
        .stall                    (stall),
        .mem_err                  (mem_err),
        .MEM_AluResult            (MEM_AluResult),
        .MEM_rd                   (MEM_rd),
        .MEM_regF_wr              (MEM_regF_wr),
        .outWB                    (outWB),
        .outJL                    (outJL),
        .outReadData              (outReadData),
        .outALUResult             (outALUResult),
        .outRegF_wreg             (outRegF_wreg),
        .outNextInstructionAddress(outNextInstructionAddress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] mem, input logic [4:0] wb, input logic [31:0] alu,
                         input logic [31:0] regb, input logic [4:0] rd, input logic jl,
                         input logic [31:0] link, input logic [1:0] size, input logic sgn);
        inMEM = mem; inWB = wb; inALUResult = alu; inRegB = regb; inRegF_wreg = rd;
        inJL = jl; inNextInstructionAddress = link; inSize = size; inSigned = sgn;
    endtask

    task automatic next_drive_point;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %0h want 0", dmem_req); end
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %0h want 0", stall); end
        tests_run++; if (mem_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %0h want 0", mem_err); end
        tests_run++; if (outWB !== 5'd0 || outReadData !== 32'd0) begin tests_failed++; $display("FAIL reset_latch: got wb=%0h rd=%h want 0/0", outWB, outReadData); end
        drive(2'b01, 5'd1, 32'h10, 32'd0, 5'd1, 1'b0, 32'd0, 2'b10, 1'b0);
        #1;
        tests_run++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL reset_gate: got req=%0h stall=%0h want 0/0", dmem_req, stall); end
        next_drive_point();
        rst = 1'b1;
        drive(2'b10, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 2'b10, 1'b0);
    endtask

    task automatic test_load_word;
        int stalls;
        next_drive_point();
        drive(2'b01, 5'd1, 32'h10, 32'd0, 5'd7, 1'b0, 32'd0, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin tests_failed++; $display("FAIL load_req: got req=%0h we=%0h want 1/0", dmem_req, dmem_we); end
        tests_run++; if (dmem_addr !== 32'h10 || dmem_be !== 4'hF) begin tests_failed++; $display("FAIL load_addr_be: got %h/%h want 00000010/f", dmem_addr, dmem_be); end
        stalls = (stall === 1'b1) ? 1 : 0;
        repeat (3) begin
            next_drive_point();
            @(posedge clk);
            if (stall === 1'b1) stalls++;
        end
        tests_run++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h10) begin tests_failed++; $display("FAIL load_hold: got req=%0h addr=%h want 1/00000010", dmem_req, dmem_addr); end
        next_drive_point();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(posedge clk);
        if (stall === 1'b1) stalls++;
        tests_run++; if (stalls != 4) begin tests_failed++; $display("FAIL load_stall_cycles: got %0d want 4", stalls); end
        next_drive_point();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        drive(2'b10, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (outReadData !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_data: got %h want deadbeef", outReadData); end
        tests_run++; if (outWB !== 5'd1 || outRegF_wreg !== 5'd7) begin tests_failed++; $display("FAIL load_wb: got wb=%0h rd=%0d want 1/7", outWB, outRegF_wreg); end
        tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL load_req_drop: got %0h want 0", dmem_req); end
    endtask

    task automatic test_store;
        next_drive_point();
        drive(2'b11, 5'd1, 32'h20, 32'h12345678, 5'd3, 1'b0, 32'd0, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'hF) begin tests_failed++; $display("FAIL store_req: got req=%0h we=%0h be=%h want 1/1/f", dmem_req, dmem_we, dmem_be); end
        tests_run++; if (dmem_wdata !== 32'h12345678 || dmem_addr !== 32'h20) begin tests_failed++; $display("FAIL store_data: got %h@%h want 12345678@00000020", dmem_wdata, dmem_addr); end
        tests_run++; if (stall !== 1'b1 || MEM_regF_wr !== 1'b0) begin tests_failed++; $display("FAIL store_stall_fwd: got stall=%0h fwd_wr=%0h want 1/0", stall, MEM_regF_wr); end
        next_drive_point();
        dmem_ack = 1'b1;
        @(posedge clk);
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL store_ack_stall: got %0h want 0", stall); end
        next_drive_point();
        dmem_ack = 1'b0;
        drive(2'b10, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (outWB !== 5'd0 || outALUResult !== 32'h20) begin tests_failed++; $display("FAIL store_latch: got wb=%0h alu=%h want 0/00000020", outWB, outALUResult); end
    endtask

    task automatic test_alu_op;
        next_drive_point();
        drive(2'b10, 5'd1, 32'hCAFE0000, 32'd0, 5'd5, 1'b0, 32'd0, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL alu_noreq: got req=%0h stall=%0h want 0/0", dmem_req, stall); end
        tests_run++; if (MEM_rd !== 5'd5 || MEM_regF_wr !== 1'b1 || MEM_AluResult !== 32'hCAFE0000) begin tests_failed++; $display("FAIL alu_fwd: got rd=%0d wr=%0h res=%h want 5/1/cafe0000", MEM_rd, MEM_regF_wr, MEM_AluResult); end
        next_drive_point();
        drive(2'b00, 5'd1, 32'h1111, 32'd0, 5'd9, 1'b1, 32'h400, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (outWB !== 5'd1 || outRegF_wreg !== 5'd5 || outALUResult !== 32'hCAFE0000) begin tests_failed++; $display("FAIL alu_latch: got wb=%0h rd=%0d alu=%h want 1/5/cafe0000", outWB, outRegF_wreg, outALUResult); end
        tests_run++; if (MEM_AluResult !== 32'h400) begin tests_failed++; $display("FAIL jl_fwd: got %h want 00000400", MEM_AluResult); end
        next_drive_point();
        @(posedge clk);
        tests_run++; if (outJL !== 1'b1 || outNextInstructionAddress !== 32'h400) begin tests_failed++; $display("FAIL jl_latch: got jl=%0h link=%h want 1/00000400", outJL, outNextInstructionAddress); end
    endtask

    task automatic test_ack_idle;
        next_drive_point();
        dmem_ack = 1'b1; dmem_rdata = 32'h00000BAD;
        @(posedge clk);
        tests_run++; if (stall !== 1'b0 || dmem_req !== 1'b0 || mem_err !== 1'b0) begin tests_failed++; $display("FAIL idle_ack: got stall=%0h req=%0h err=%0h want 0/0/0", stall, dmem_req, mem_err); end
        next_drive_point();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
    endtask

    task automatic test_timeout;
        int stalls;
        next_drive_point();
        drive(2'b01, 5'd1, 32'h40, 32'd0, 5'd4, 1'b0, 32'd0, 2'b10, 1'b0);
        stalls = 0;
        @(posedge clk);
        while (stall === 1'b1 && stalls < 100) begin
            stalls++;
            if (stalls == 8) begin
                tests_run++; if (outWB !== 5'd1 || outALUResult !== 32'h1111) begin tests_failed++; $display("FAIL timeout_hold: got wb=%0h alu=%h want 1/00001111", outWB, outALUResult); end
            end
            next_drive_point();
            @(posedge clk);
        end
        tests_run++; if (stalls != 16) begin tests_failed++; $display("FAIL timeout_stall_cycles: got %0d want 16", stalls); end
        next_drive_point();
        drive(2'b10, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (mem_err !== 1'b1 || outWB !== 5'd0) begin tests_failed++; $display("FAIL timeout_err: got err=%0h wb=%0h want 1/0", mem_err, outWB); end
        tests_run++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL timeout_idle: got req=%0h stall=%0h want 0/0", dmem_req, stall); end
    endtask

    task automatic test_reset_mid_wait;
        next_drive_point();
        drive(2'b01, 5'd1, 32'h50, 32'd0, 5'd2, 1'b0, 32'd0, 2'b10, 1'b0);
        next_drive_point();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests_run++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL abort_req: got req=%0h stall=%0h want 0/0", dmem_req, stall); end
        tests_run++; if (mem_err !== 1'b0 || outWB !== 5'd0) begin tests_failed++; $display("FAIL abort_clear: got err=%0h wb=%0h want 0/0", mem_err, outWB); end
        next_drive_point();
        rst = 1'b1;
        drive(2'b01, 5'd1, 32'h60, 32'd0, 5'd6, 1'b0, 32'd0, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h60 || stall !== 1'b1) begin tests_failed++; $display("FAIL restart_req: got req=%0h addr=%h stall=%0h want 1/00000060/1", dmem_req, dmem_addr, stall); end
        next_drive_point();
        dmem_ack = 1'b1; dmem_rdata = 32'h01020304;
        next_drive_point();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        drive(2'b10, 5'd1, 32'h7777, 32'd0, 5'd2, 1'b0, 32'd0, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (outReadData !== 32'h01020304 || outRegF_wreg !== 5'd6) begin tests_failed++; $display("FAIL restart_latch: got %h rd=%0d want 01020304/6", outReadData, outRegF_wreg); end
    endtask

    task automatic test_misaligned;
        next_drive_point();
        drive(2'b01, 5'd1, 32'h22, 32'd0, 5'd3, 1'b0, 32'd0, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (dmem_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b0) begin tests_failed++; $display("FAIL misalign_noreq: got req=%0h stall=%0h err=%0h want 0/0/0", dmem_req, stall, mem_err); end
        tests_run++; if (outWB !== 5'd1) begin tests_failed++; $display("FAIL misalign_prev: got wb=%0h want 1", outWB); end
        next_drive_point();
        drive(2'b10, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (mem_err !== 1'b1 || outWB !== 5'd0) begin tests_failed++; $display("FAIL misalign_err: got err=%0h wb=%0h want 1/0", mem_err, outWB); end
    endtask

`ifdef SUBWORD_ACCESS_EN
    task automatic test_subword;
        next_drive_point();
        drive(2'b01, 5'd1, 32'h13, 32'd0, 5'd8, 1'b0, 32'd0, 2'b00, 1'b1);
        @(posedge clk);
        tests_run++; if (dmem_req !== 1'b1 || dmem_be !== 4'b1000) begin tests_failed++; $display("FAIL lb_be: got req=%0h be=%b want 1/1000", dmem_req, dmem_be); end
        next_drive_point();
        dmem_ack = 1'b1; dmem_rdata = 32'h80112233;
        next_drive_point();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        drive(2'b10, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 2'b10, 1'b0);
        @(posedge clk);
        tests_run++; if (outReadData !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb_data: got %h want ffffff80", outReadData); end
    endtask
`endif

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_load_word();
        test_store();
        test_alu_op();
        test_ack_idle();
        test_timeout();
        test_reset_mid_wait();
        test_misaligned();
`ifdef SUBWORD_ACCESS_EN
        test_subword();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
